id_issue: RTL and testbench
===========================

// Module: id_issue
// PURPOSE
//  RV32I decode/issue stage between the IF/ID latch and EX; direct client of regfile.
//  - Decodes the fetched instruction and drives the regfile read ports.
//  - Selects operands from regfile data or EX/MEM forwarding buses.
//  - Detects load-use hazards and registers the ID/EX bundle under a valid/ready handshake.
// PARAMETERS
//  XLEN      32   datapath width (RegBus)
//  RADDR_W   5    register address width (RegNumLog2)
// PORTS
//  clk         in   1     clock, all state on posedge
//  rst         in   1     synchronous, active-low reset
//  inst_i      in   32    instruction from IF/ID
//  pc_i        in   XLEN  pc of inst_i
//  valid_i     in   1     inst_i/pc_i valid
//  ready_o     out  1     stage accepts inst_i this cycle
//  re1_o       out  1     regfile read enable port 1
//  raddr1_o    out  5     regfile read address port 1 (= inst[19:15])
//  rdata1_i    in   XLEN  regfile read data port 1 (WB bypass already applied)
//  re2_o       out  1     regfile read enable port 2
//  raddr2_o    out  5     regfile read address port 2 (= inst[24:20])
//  rdata2_i    in   XLEN  regfile read data port 2
//  ex_wreg_i   in   1     EX-stage instr writes rd
//  ex_wd_i     in   5     EX-stage rd
//  ex_wdata_i  in   XLEN  EX-stage result
//  ex_load_i   in   1     EX-stage instr is a load (result not ready)
//  mem_wreg_i  in   1     MEM-stage instr writes rd
//  mem_wd_i    in   5     MEM-stage rd
//  mem_wdata_i in   XLEN  MEM-stage result
//  flush_i     in   1     redirect: kill ID contents and the input instruction
//  ready_i     in   1     EX accepts bundle
//  valid_o     out  1     bundle valid
//  pc_o, reg1_o, reg2_o, imm_o   out  XLEN  pc, operand1, operand2, sign-extended imm
//  rd_o        out  5     destination reg
//  wreg_o      out  1     writes rd
//  opcode_o    out  7     inst[6:0]
//  funct3_o    out  3     inst[14:12]
//  funct7b5_o  out  1     inst[30]
// BEHAVIOUR
//  - Reset (rst=0 at posedge): every registered output clears to 0; valid_o=0.
//  - Decode is combinational on inst_i.
//    - LUI/AUIPC/JAL: re1=re2=0.
//    - JALR/LOAD/OP-IMM: re1=1.
//    - BRANCH/STORE/OP: re1=re2=1.
//    - wreg=1 except BRANCH/STORE.
//    - rd=0 forces wreg=0.
//    - Unknown opcode: NOP (re*=0, wreg=0, imm=0).
//    - When valid_i=0, re1_o=re2_o=0.
//  - Imm formats I/S/B/U/J per opcode; bit 31 sign-extends; B/J LSB=0.
//  - Operand select, per port: raddr=0 gives 0; else EX match (ex_wreg_i & ex_wd_i==raddr),
//    then MEM match, then rdata_i. Port with re=0 gives 0.
//  - Stall (load-use): valid_i & ex_load_i & ex_wreg_i & ex_wd_i!=0 & ex_wd_i matches an
//    enabled raddr.
//  - Handshake: adv = !valid_o | ready_i; ready_o = adv & !stall.
//  - Latency 1: accepted inst appears on outputs the next cycle.
//  - Posedge update priority:
//    - flush_i: valid_o <= 0 (input dropped).
//    - else if adv: valid_o <= valid_i & !stall; bundle loaded when that is 1.
//    - else hold all outputs.
//  - Stall with adv: bubble (valid_o=0); input is retried the next cycle.
//  - Bundle fields hold their old values while valid_o=0.
//  - ready_o=1 during flush; IF must discard as well.
//  - Reset mid-stall or mid-hold: pending bundle is lost; no replay.
// CONFIGURATION
//  ID_FORWARD_EN defined: EX/MEM forwarding and load-use-only stall, as above.
//  ID_FORWARD_EN undefined: no forwarding; operands come only from rdata*_i.
//    - stall = valid_i & an enabled raddr!=0 matches an EX or MEM writer (wreg=1).
//    - ex_load_i is ignored.
// TESTING
//  1 addi x1,x0,5 (0x00500093), ready_i=1
//    -> next cycle valid_o=1, re1_o=1, raddr1_o=0, reg1_o=0, imm_o=5, rd_o=1, wreg_o=1.
//  2 add x3,x1,x2 with ex_wd_i=1/0xAA, mem_wd_i=2/0xBB (FWD_EN)
//    -> reg1_o=0xAA, reg2_o=0xBB.
//  3 Same as 2 with ex_wd_i=mem_wd_i=1
//    -> reg1_o from EX; rd x0 writer with ex_wreg_i=1 -> no forward, reg=0.
//  4 ex_load_i=1, ex_wd_i=5, inst uses rs2=x5
//    -> ready_o=0 one cycle, valid_o=0 bubble; then issued with forwarded/regfile data.
//  5 ready_i=0 with valid_o=1 for 3 cycles -> outputs stable, ready_o=0;
//    flush_i=1 -> valid_o=0 next cycle.
//  6 beq (0xFE208EE3): wreg_o=0, imm_o=0xFFFFFFFC;
//    rst=0 mid-stream -> all outputs 0 at next posedge.

Source files
------------

// File: rtl/id_issue_if.sv
// -----------------------------------------------------------------------------
// id_issue_if
// Purpose : ID -> EX issue bundle with a valid/ready handshake. The decode
//           stage drives the bundle and valid; the execute stage returns ready.
// Signals : valid     bundle valid
//           ready     EX accepts the bundle this cycle
//           pc        pc of the issued instruction
//           reg1/reg2 resolved source operands
//           imm       sign-extended immediate
//           rd/wreg   destination register and its write enable
//           opcode    inst[6:0]
//           funct3    inst[14:12]
//           funct7b5  inst[30]
// Modports: master (decode side), slave (execute side)
// -----------------------------------------------------------------------------
interface id_issue_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               valid;
    logic               ready;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    reg1;
    logic [XLEN-1:0]    reg2;
    logic [XLEN-1:0]    imm;
    logic [RADDR_W-1:0] rd;
    logic               wreg;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               funct7b5;

    modport master (
        output valid, pc, reg1, reg2, imm, rd, wreg, opcode, funct3, funct7b5,
        input  ready
    );

    modport slave (
        input  valid, pc, reg1, reg2, imm, rd, wreg, opcode, funct3, funct7b5,
        output ready
    );
endinterface

// File: rtl/id_issue.sv
// -----------------------------------------------------------------------------
// id_issue
// Purpose : RV32I decode/issue stage. Decodes the IF/ID instruction, drives the
//           regfile read ports, resolves operands, detects hazards and registers
//           the ID/EX bundle under a valid/ready handshake (latency 1).
// Ports   : clk, rst (synchronous, active-low)
//           inst_i, pc_i, valid_i, ready_o          IF/ID side
//           re*_o, raddr*_o, rdata*_i               regfile read ports
//           ex_wreg_i, ex_wd_i, ex_wdata_i, ex_load_i  EX-stage writer
//           mem_wreg_i, mem_wd_i, mem_wdata_i       MEM-stage writer
//           flush_i                                 redirect, kills ID and input
//           ex                                      ID/EX bundle (id_issue_if.master)
// Config  : ID_FORWARD_EN defined   -> EX/MEM forwarding, stall only on load-use.
//           ID_FORWARD_EN undefined -> operands from regfile only, stall on any
//                                      pending EX/MEM writer of a source register.
// -----------------------------------------------------------------------------
module id_issue #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        inst_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               re1_o,
    output logic [RADDR_W-1:0] raddr1_o,
    input  logic [XLEN-1:0]    rdata1_i,
    output logic               re2_o,
    output logic [RADDR_W-1:0] raddr2_o,
    input  logic [XLEN-1:0]    rdata2_i,
    input  logic               ex_wreg_i,
    input  logic [RADDR_W-1:0] ex_wd_i,
    input  logic [XLEN-1:0]    ex_wdata_i,
    input  logic               ex_load_i,
    input  logic               mem_wreg_i,
    input  logic [RADDR_W-1:0] mem_wd_i,
    input  logic [XLEN-1:0]    mem_wdata_i,
    input  logic               flush_i,
    id_issue_if.master         ex
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Immediate per instruction format; R-type and unknown opcodes give 0.
    function automatic logic signed [31:0] imm_gen(input logic [31:0] ins);
        logic signed [31:0] imm;
        case (ins[6:0])
            OP_JALR, OP_LOAD, OP_IMM: imm = {{20{ins[31]}}, ins[31:20]};
            OP_STORE:                 imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OP_BRANCH:                imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm = {ins[31:12], 12'b0};
            OP_JAL:                   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:                  imm = '0;
        endcase
        return imm;
    endfunction

    logic                   dec_re1;
    logic                   dec_re2;
    logic                   dec_wr;
    logic                   wreg_d;
    logic signed [XLEN-1:0] imm_d;
    logic                   ex_hit1;
    logic                   ex_hit2;
    logic                   mem_hit1;
    logic                   mem_hit2;
    logic [XLEN-1:0]        opnd1;
    logic [XLEN-1:0]        opnd2;
    logic                   stall;
    logic                   adv;
    logic                   issue;

    logic                   vld_p1;
    logic [XLEN-1:0]        pc_p1;
    logic [XLEN-1:0]        reg1_p1;
    logic [XLEN-1:0]        reg2_p1;
    logic signed [XLEN-1:0] imm_p1;
    logic [RADDR_W-1:0]     rd_p1;
    logic                   wreg_p1;
    logic [6:0]             opcode_p1;
    logic [2:0]             funct3_p1;
    logic                   funct7b5_p1;

    // ---- stage 0: combinational decode, operand select, hazard detect ----
    always_comb begin
        dec_re1 = 1'b0;
        dec_re2 = 1'b0;
        dec_wr  = 1'b0;
        case (inst_i[6:0])
            OP_LUI, OP_AUIPC, OP_JAL: dec_wr = 1'b1;
            OP_JALR, OP_LOAD, OP_IMM: begin
                dec_re1 = 1'b1;
                dec_wr  = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                dec_re1 = 1'b1;
                dec_re2 = 1'b1;
            end
            OP_OP: begin
                dec_re1 = 1'b1;
                dec_re2 = 1'b1;
                dec_wr  = 1'b1;
            end
            default: ;
        endcase
    end

    assign raddr1_o = inst_i[19:15];
    assign raddr2_o = inst_i[24:20];
    assign re1_o    = valid_i & dec_re1;
    assign re2_o    = valid_i & dec_re2;
    assign wreg_d   = dec_wr & (inst_i[11:7] != 5'd0);
    assign imm_d    = XLEN'(imm_gen(inst_i));

    assign ex_hit1  = ex_wreg_i  & (ex_wd_i  == raddr1_o);
    assign ex_hit2  = ex_wreg_i  & (ex_wd_i  == raddr2_o);
    assign mem_hit1 = mem_wreg_i & (mem_wd_i == raddr1_o);
    assign mem_hit2 = mem_wreg_i & (mem_wd_i == raddr2_o);

`ifdef ID_FORWARD_EN
    // x0 and disabled ports read as zero; the younger EX result wins over MEM.
    function automatic logic [XLEN-1:0] select_operand(
        input logic               re,
        input logic [RADDR_W-1:0] addr,
        input logic [XLEN-1:0]    rdata,
        input logic               ex_hit,
        input logic [XLEN-1:0]    ex_data,
        input logic               mem_hit,
        input logic [XLEN-1:0]    mem_data
    );
        if (!re || addr == '0) return '0;
        if (ex_hit)            return ex_data;
        if (mem_hit)           return mem_data;
        return rdata;
    endfunction

    assign opnd1 = select_operand(re1_o, raddr1_o, rdata1_i, ex_hit1, ex_wdata_i, mem_hit1, mem_wdata_i);
    assign opnd2 = select_operand(re2_o, raddr2_o, rdata2_i, ex_hit2, ex_wdata_i, mem_hit2, mem_wdata_i);

    // Only a load in EX cannot be forwarded yet.
    assign stall = valid_i & ex_load_i & (ex_wd_i != '0) &
                   ((re1_o & ex_hit1) | (re2_o & ex_hit2));
`else
    function automatic logic [XLEN-1:0] select_operand(
        input logic               re,
        input logic [RADDR_W-1:0] addr,
        input logic [XLEN-1:0]    rdata
    );
        if (!re || addr == '0) return '0;
        return rdata;
    endfunction

    logic unused_fwd;

    assign opnd1 = select_operand(re1_o, raddr1_o, rdata1_i);
    assign opnd2 = select_operand(re2_o, raddr2_o, rdata2_i);

    // Without bypass paths, any in-flight writer of a source register blocks issue.
    assign stall = valid_i &
                   ((re1_o & (raddr1_o != '0) & (ex_hit1 | mem_hit1)) |
                    (re2_o & (raddr2_o != '0) & (ex_hit2 | mem_hit2)));

    assign unused_fwd = ^{ex_load_i, ex_wdata_i, mem_wdata_i};
`endif

    assign adv     = ~vld_p1 | ex.ready;
    assign issue   = valid_i & ~stall;
    // During a flush the input is dropped, so IF may always move on.
    assign ready_o = flush_i | (adv & ~stall);

    // ---- stage 1: ID/EX bundle register ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            reg1_p1     <= '0;
            reg2_p1     <= '0;
            imm_p1      <= '0;
            rd_p1       <= '0;
            wreg_p1     <= 1'b0;
            opcode_p1   <= '0;
            funct3_p1   <= '0;
            funct7b5_p1 <= 1'b0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
        end else if (adv) begin
            vld_p1 <= issue;
            if (issue) begin
                pc_p1       <= pc_i;
                reg1_p1     <= opnd1;
                reg2_p1     <= opnd2;
                imm_p1      <= imm_d;
                rd_p1       <= inst_i[11:7];
                wreg_p1     <= wreg_d;
                opcode_p1   <= inst_i[6:0];
                funct3_p1   <= inst_i[14:12];
                funct7b5_p1 <= inst_i[30];
            end
        end
    end

    assign ex.valid    = vld_p1;
    assign ex.pc       = pc_p1;
    assign ex.reg1     = reg1_p1;
    assign ex.reg2     = reg2_p1;
    assign ex.imm      = imm_p1;
    assign ex.rd       = rd_p1;
    assign ex.wreg     = wreg_p1;
    assign ex.opcode   = opcode_p1;
    assign ex.funct3   = funct3_p1;
    assign ex.funct7b5 = funct7b5_p1;
endmodule

// File: tb/tb_id_issue.sv
`timescale 1ns/1ps
module tb_id_issue;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid_in;
    logic        ready_out;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        ex_wreg, ex_load, mem_wreg, flush;
    logic [4:0]  ex_wd, mem_wd;
    logic [31:0] ex_wdata, mem_wdata;

    int nvec  = 0;
    int nfail = 0;

`ifdef ID_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    always #5 clk = ~clk;

    id_issue_if #(.XLEN(32), .RADDR_W(5)) exb ();

    id_issue #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .inst_i(inst), .pc_i(pc), .valid_i(valid_in), .ready_o(ready_out),
        .re1_o(re1), .raddr1_o(raddr1), .rdata1_i(rdata1),
        .re2_o(re2), .raddr2_o(raddr2), .rdata2_i(rdata2),
        .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata), .ex_load_i(ex_load),
        .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
        .flush_i(flush), .ex(exb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        re1;
        logic        re2;
        logic        wreg;
        logic [31:0] imm;
    } dec_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc, reg1, reg2, imm;
        logic [4:0]  rd;
        logic        wreg;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7b5;
    } bundle_t;

    bundle_t m;

    function automatic dec_t ref_decode(input logic [31:0] ins, input logic v);
        dec_t d;
        int   s;
        int   nrd;
        bit   wr;
        s     = $signed(ins);
        nrd   = 0;
        wr    = 1'b0;
        d.imm = 32'd0;
        case (ins[6:0])
            7'h37, 7'h17: begin wr = 1'b1; d.imm = ins & 32'hFFFF_F000; end
            7'h6F: begin
                wr    = 1'b1;
                d.imm = 32'(((s >>> 31) << 20) | (int'(ins[19:12]) << 12) |
                            (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1));
            end
            7'h67, 7'h03, 7'h13: begin nrd = 1; wr = 1'b1; d.imm = 32'(s >>> 20); end
            7'h23: begin nrd = 2; d.imm = 32'(((s >>> 25) << 5) | int'(ins[11:7])); end
            7'h63: begin
                nrd   = 2;
                d.imm = 32'(((s >>> 31) << 12) | (int'(ins[7]) << 11) |
                            (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1));
            end
            7'h33: begin nrd = 2; wr = 1'b1; end
            default: ;
        endcase
        d.re1  = v && (nrd >= 1);
        d.re2  = v && (nrd == 2);
        d.wreg = wr && (ins[11:7] != 5'd0);
        return d;
    endfunction

    function automatic logic [31:0] ref_operand(input bit re, input logic [4:0] a, input logic [31:0] rf);
        if (!re || a == 5'd0) return 32'd0;
        if (FWD && ex_wreg && ex_wd == a)   return ex_wdata;
        if (FWD && mem_wreg && mem_wd == a) return mem_wdata;
        return rf;
    endfunction

    function automatic bit pending_writer(input logic [4:0] a);
        return (ex_wreg && ex_wd == a) || (mem_wreg && mem_wd == a);
    endfunction

    function automatic bit ref_stall(input dec_t d, input logic [31:0] ins);
        logic [4:0] a1, a2;
        a1 = ins[19:15];
        a2 = ins[24:20];
        if (!valid_in) return 1'b0;
        if (FWD)
            return ex_load && ex_wreg && ex_wd != 5'd0 &&
                   ((d.re1 && a1 == ex_wd) || (d.re2 && a2 == ex_wd));
        return (d.re1 && a1 != 5'd0 && pending_writer(a1)) ||
               (d.re2 && a2 != 5'd0 && pending_writer(a2));
    endfunction

    task automatic check_bundle(input string tag);
        check({tag, "_valid"}, exb.valid, m.valid);
        check({tag, "_pc"},    exb.pc,    m.pc);
        check({tag, "_reg1"},  exb.reg1,  m.reg1);
        check({tag, "_reg2"},  exb.reg2,  m.reg2);
        check({tag, "_imm"},   exb.imm,   m.imm);
        check({tag, "_rd"},    exb.rd,    m.rd);
        check({tag, "_wreg"},  exb.wreg,  m.wreg);
        check({tag, "_op"},    exb.opcode, m.op);
        check({tag, "_f3"},    exb.funct3, m.f3);
        check({tag, "_f7b5"},  exb.funct7b5, m.f7b5);
    endtask

    // Inputs must already be driven (after a negedge).
    task automatic model_cycle();
        dec_t d;
        bit   st, adv, iss;
        #1;
        d   = ref_decode(inst, valid_in);
        st  = ref_stall(d, inst);
        adv = !m.valid || exb.ready;
        check("rnd_ready",  ready_out, flush || (adv && !st));
        check("rnd_re1",    re1, d.re1);
        check("rnd_re2",    re2, d.re2);
        check("rnd_raddr1", raddr1, inst[19:15]);
        check("rnd_raddr2", raddr2, inst[24:20]);
        if (!rst) begin
            m = '{default: '0};
        end else if (flush) begin
            m.valid = 1'b0;
        end else if (adv) begin
            iss     = valid_in && !st;
            m.valid = iss;
            if (iss) begin
                m.pc   = pc;
                m.reg1 = ref_operand(d.re1, inst[19:15], rdata1);
                m.reg2 = ref_operand(d.re2, inst[24:20], rdata2);
                m.imm  = d.imm;
                m.rd   = inst[11:7];
                m.wreg = d.wreg;
                m.op   = inst[6:0];
                m.f3   = inst[14:12];
                m.f7b5 = inst[30];
            end
        end
        @(posedge clk);
        #1;
        check_bundle("rnd");
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 9))
            0: ins[6:0] = 7'h37;
            1: ins[6:0] = 7'h17;
            2: ins[6:0] = 7'h6F;
            3: ins[6:0] = 7'h67;
            4: ins[6:0] = 7'h03;
            5: ins[6:0] = 7'h13;
            6: ins[6:0] = 7'h63;
            7: ins[6:0] = 7'h23;
            8: ins[6:0] = 7'h33;
            default: ;
        endcase
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    // ---------------- directed table ----------------
    // Field order: inst, rdata1, rdata2, ex_wreg, ex_wd, ex_wdata, mem_wreg, mem_wd,
    // mem_wdata, e_ready, e_re1, e_re2, e_reg1, e_reg2, e_imm, e_rd, e_wreg
    typedef struct {
        logic [31:0] inst, rdata1, rdata2;
        logic        ex_wreg;
        logic [4:0]  ex_wd;
        logic [31:0] ex_wdata;
        logic        mem_wreg;
        logic [4:0]  mem_wd;
        logic [31:0] mem_wdata;
        logic        e_ready, e_re1, e_re2;
        logic [31:0] e_reg1, e_reg2, e_imm;
        logic [4:0]  e_rd;
        logic        e_wreg;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{32'h00500093, 32'h1234, 32'h5678, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'd5, 1, 1};
        tbl[1]  = '{32'h002081B3, 32'h11, 32'h22, 1, 1, 32'hAA, 1, 2, 32'hBB, FWD, 1, 1, 32'hAA, 32'hBB, 0, 3, 1};
        tbl[2]  = '{32'h002081B3, 32'h11, 32'h22, 1, 1, 32'hAA, 1, 1, 32'hBB, FWD, 1, 1, 32'hAA, 32'h22, 0, 3, 1};
        tbl[3]  = '{32'h000001B3, 32'h11, 32'h22, 1, 0, 32'hAA, 0, 0, 0, 1, 1, 1, 0, 0, 0, 3, 1};
        tbl[4]  = '{32'hFE208EE3, 32'h33, 32'h44, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h33, 32'h44, 32'hFFFFFFFC, 29, 0};
        tbl[5]  = '{32'h123452B7, 32'h55, 32'h56, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h12345000, 5, 1};
        tbl[6]  = '{32'h0020A423, 32'h66, 32'h77, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h66, 32'h77, 32'd8, 8, 0};
        tbl[7]  = '{32'hFFFFFFFF, 32'h88, 32'h99, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 31, 0};
        tbl[8]  = '{32'hFFF00093, 32'h1, 32'h2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'hFFFFFFFF, 1, 1};
        tbl[9]  = '{32'h00500013, 32'h1, 32'h2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'd5, 0, 0};
        tbl[10] = '{32'h008000EF, 32'h1, 32'h2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'd8, 1, 1};

        rst = 1'b0; inst = 32'h0; pc = 32'h0; valid_in = 1'b0;
        rdata1 = 32'h0; rdata2 = 32'h0; ex_wreg = 1'b0; ex_wd = 5'd0; ex_wdata = 32'h0;
        ex_load = 1'b0; mem_wreg = 1'b0; mem_wd = 5'd0; mem_wdata = 32'h0;
        flush = 1'b0; exb.ready = 1'b1;
        m = '{default: '0};

        repeat (3) @(posedge clk);
        #1;
        check_bundle("reset");
        @(negedge clk);
        rst = 1'b1;

        // ---- table vectors ----
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            inst = tbl[i].inst; pc = 32'h1000 + 32'(i * 4); valid_in = 1'b1;
            rdata1 = tbl[i].rdata1; rdata2 = tbl[i].rdata2;
            ex_wreg = tbl[i].ex_wreg; ex_wd = tbl[i].ex_wd; ex_wdata = tbl[i].ex_wdata;
            mem_wreg = tbl[i].mem_wreg; mem_wd = tbl[i].mem_wd; mem_wdata = tbl[i].mem_wdata;
            ex_load = 1'b0; flush = 1'b0; exb.ready = 1'b1;
            #1;
            check($sformatf("tbl%0d_ready", i), ready_out, tbl[i].e_ready);
            check($sformatf("tbl%0d_re1", i), re1, tbl[i].e_re1);
            check($sformatf("tbl%0d_re2", i), re2, tbl[i].e_re2);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_valid", i), exb.valid, tbl[i].e_ready);
            if (tbl[i].e_ready) begin
                check($sformatf("tbl%0d_pc", i),   exb.pc,   32'h1000 + 32'(i * 4));
                check($sformatf("tbl%0d_reg1", i), exb.reg1, tbl[i].e_reg1);
                check($sformatf("tbl%0d_reg2", i), exb.reg2, tbl[i].e_reg2);
                check($sformatf("tbl%0d_imm", i),  exb.imm,  tbl[i].e_imm);
                check($sformatf("tbl%0d_rd", i),   exb.rd,   tbl[i].e_rd);
                check($sformatf("tbl%0d_wreg", i), exb.wreg, tbl[i].e_wreg);
                check($sformatf("tbl%0d_op", i),   exb.opcode, tbl[i].inst[6:0]);
            end
        end

        // ---- load-use: add x3,x0,x5 behind a load of x5 ----
        @(negedge clk);
        inst = 32'h005001B3; pc = 32'h1800; valid_in = 1'b1;
        ex_load = 1'b1; ex_wreg = 1'b1; ex_wd = 5'd5; ex_wdata = 32'hDEAD;
        mem_wreg = 1'b0; rdata2 = 32'h99;
        #1;
        check("lu_ready_stall", ready_out, 1'b0);
        @(posedge clk);
        #1;
        check("lu_bubble", exb.valid, 1'b0);
        @(negedge clk);
        ex_load = 1'b0; ex_wreg = 1'b0;
        if (FWD) begin
            mem_wreg = 1'b1; mem_wd = 5'd5; mem_wdata = 32'h77; rdata2 = 32'h12;
        end else begin
            mem_wreg = 1'b0; rdata2 = 32'h77;
        end
        #1;
        check("lu_ready_retry", ready_out, 1'b1);
        @(posedge clk);
        #1;
        check("lu_issue_valid", exb.valid, 1'b1);
        check("lu_issue_reg2", exb.reg2, 32'h77);
        check("lu_issue_pc", exb.pc, 32'h1800);

        // ---- backpressure hold, then flush ----
        @(negedge clk);
        inst = 32'h00500093; pc = 32'h2000; valid_in = 1'b1;
        mem_wreg = 1'b0; ex_wreg = 1'b0; exb.ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_first_valid", exb.valid, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exb.ready = 1'b0; inst = 32'h00A00113; pc = 32'h3000;
            #1;
            check($sformatf("hold%0d_ready", k), ready_out, 1'b0);
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_valid", k), exb.valid, 1'b1);
            check($sformatf("hold%0d_imm", k), exb.imm, 32'd5);
            check($sformatf("hold%0d_pc", k), exb.pc, 32'h2000);
            check($sformatf("hold%0d_rd", k), exb.rd, 5'd1);
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_ready", ready_out, 1'b1);
        @(posedge clk);
        #1;
        check("flush_valid", exb.valid, 1'b0);
        check("flush_imm_held", exb.imm, 32'd5);

        // ---- reset mid-stream ----
        @(negedge clk);
        flush = 1'b0; exb.ready = 1'b1;
        inst = 32'hFE208EE3; pc = 32'h4000; rdata1 = 32'h33; rdata2 = 32'h44;
        @(posedge clk);
        #1;
        check("beq_valid", exb.valid, 1'b1);
        check("beq_wreg", exb.wreg, 1'b0);
        check("beq_imm", exb.imm, 32'hFFFFFFFC);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        m = '{default: '0};
        check_bundle("midrst");
        @(negedge clk);
        rst = 1'b1;

        // ---- randomized against the reference model ----
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 49) != 0);
            inst      = rand_inst();
            pc        = $urandom;
            valid_in  = ($urandom_range(0, 4) != 0);
            rdata1    = $urandom;
            rdata2    = $urandom;
            ex_wreg   = $urandom_range(0, 1);
            ex_wd     = 5'($urandom_range(0, 3));
            ex_wdata  = $urandom;
            ex_load   = $urandom_range(0, 1);
            mem_wreg  = $urandom_range(0, 1);
            mem_wd    = 5'($urandom_range(0, 3));
            mem_wdata = $urandom;
            flush     = ($urandom_range(0, 19) == 0);
            exb.ready = ($urandom_range(0, 3) != 0);
            model_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
